// File: rtl/iic_slave.sv
// rtl/iic_slave.sv - I2C responder with one byte write/read data path
//
// Purpose: answers at DEV_ADDR on an open-drain I2C bus. Writes from the master
// land in data_out with a one-clk wr_valid strobe. Reads return data_in, which
// is reloaded each time the master ACKs a byte.
//
// Ports:
//   clk      - system clock; all flops use its rising edge
//   rst_n    - asynchronous active-low reset
//   scl      - bus clock from the master, asynchronous to clk
//   sda      - bus data; this block drives only 0 or high-Z
//   data_in  - byte returned to the master on reads
//   data_out - last byte written by the master
//   wr_valid - one-clk pulse when data_out is updated
//   busy     - high while this device is addressed
`timescale 1ns/1ps
module iic_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       wr_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  scl_sync_q, scl_sync_d;
  logic [2:0]  sda_sync_q, sda_sync_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        wr_valid_q, wr_valid_d;

  logic        scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  shift_in;

  // Bits [1:0] synchronize; bit [2] is the previous synchronized value.
  assign scl_sync_d = {scl_sync_q[1:0], scl};
  assign sda_sync_d = {sda_sync_q[1:0], sda};
  assign scl_s      = scl_sync_q[1];
  assign sda_s      = sda_sync_q[1];
  assign scl_rise   = scl_s & ~scl_sync_q[2];
  assign scl_fall   = ~scl_s & scl_sync_q[2];
  assign start_det  = sda_sync_q[2] & ~sda_s & scl_s & scl_sync_q[2];
  assign stop_det   = ~sda_sync_q[2] & sda_s & scl_s & scl_sync_q[2];
  assign shift_in   = {shift_q[6:0], sda_s};

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign data_out = data_out_q;
  assign wr_valid = wr_valid_q;
  assign busy     = (state_q == ADDR_ACK) || (state_q == WR_DATA) || (state_q == WR_ACK) ||
                    (state_q == RD_DATA)  || (state_q == RD_ACK);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    data_out_d = data_out_q;
    wr_valid_d = 1'b0;
    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (shift_in[7:1] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = shift_in[0];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // The ACK states use sda_oe_q as their phase: first falling edge
        // starts the ACK, the second one ends it.
        ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (rw_q) begin
            shift_d  = data_in;
            sda_oe_d = ~data_in[7];
            cnt_d    = 3'd0;
            state_d  = RD_DATA;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            state_d  = WR_DATA;
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            data_out_d = shift_in;
            wr_valid_d = 1'b1;
            state_d    = WR_ACK;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            state_d  = WR_DATA;
          end
        end
        // cnt counts falling edges here; MSB was already driven on entry.
        RD_DATA: if (scl_fall) begin
          if (cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            state_d  = RD_ACK;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
            cnt_d    = cnt_q + 3'd1;
          end
        end
        // A falling edge seen here always follows a sampled master ACK,
        // since a NACK has already moved the state to IGNORE.
        RD_ACK: begin
          if (scl_rise && sda_s) begin
            state_d = IGNORE;
          end else if (scl_fall) begin
            shift_d  = data_in;
            sda_oe_d = ~data_in[7];
            cnt_d    = 3'd0;
            state_d  = RD_DATA;
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      data_out_q <= 8'h00;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
    end
  end

endmodule

// File: tb/tb_iic_slave.sv
// tb/tb_iic_slave.sv - bit-banged I2C master bench for iic_slave
`timescale 1ns/1ps
module tb_iic_slave;
  localparam logic [6:0] DEV = 7'h50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       m_oe = 1'b0;
  logic [7:0] data_in = 8'h00;
  wire  [7:0] data_out;
  wire        wr_valid;
  wire        busy;
  wire        sda_w;

  pullup (sda_w);
  assign sda_w = m_oe ? 1'b0 : 1'bz;

  iic_slave #(.DEV_ADDR(DEV)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl_m), .sda(sda_w),
    .data_in(data_in), .data_out(data_out), .wr_valid(wr_valid), .busy(busy)
  );

  always #10 clk = ~clk;

  int checks = 0, failures = 0;
  int pulse_cnt = 0, wv_hi = 0, dut_low = 0;
  logic wv_prev = 1'b0;
  int q = 600;
  logic [7:0] exp_dout = 8'h00;
  logic [7:0] wb [4];

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wv_hi <= wv_hi + 1;
      if (!wv_prev) pulse_cnt <= pulse_cnt + 1;
    end
    wv_prev <= wr_valid;
    if (rst_n && !m_oe && sda_w === 1'b0) dut_low <= dut_low + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    m_oe = 1'b0; #(q); scl_m = 1'b1; #(q); m_oe = 1'b1; #(q); scl_m = 1'b0; #(q);
  endtask

  task automatic bus_stop();
    m_oe = 1'b1; #(q); scl_m = 1'b1; #(q); m_oe = 1'b0; #(q);
  endtask

  task automatic send_bit(input logic b, output logic s);
    m_oe = ~b; #(q); scl_m = 1'b1; #(q); s = sda_w; #(q); scl_m = 1'b0; #(q);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(v[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] v);
    logic s;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, s);
      v = {v[6:0], s};
    end
    send_bit(nack, s);
  endtask

  // Reference behaviour: a matching write ACKs every byte and updates data_out
  // once per byte; anything else leaves the bus and data_out alone.
  task automatic txn_write(input logic [7:0] addr, input int n);
    logic ack;
    logic match;
    int p0, h0, l0;
    match = (addr[7:1] == DEV) && !addr[0];
    p0 = pulse_cnt; h0 = wv_hi; l0 = dut_low;
    bus_start();
    write_byte(addr, ack);
    check("wr_addr_ack", ack, !match);
    check("busy_addressed", busy, match);
    for (int i = 0; i < n; i++) begin
      write_byte(wb[i], ack);
      check("wr_data_ack", ack, !match);
      if (match) exp_dout = wb[i];
    end
    bus_stop();
    #(2 * q);
    check("data_out", data_out, exp_dout);
    check("wr_pulses", pulse_cnt - p0, match ? n : 0);
    check("wr_pulse_width", wv_hi - h0, match ? n : 0);
    check("busy_after_stop", busy, 1'b0);
    check("sda_released", sda_w, 1'b1);
    if (!match) check("no_drive_low", dut_low - l0, 0);
  endtask

  // Matching reads return data_in for every byte; unaddressed reads see 8'hFF.
  task automatic txn_read(input logic [7:0] addr, input int n);
    logic ack;
    logic match;
    logic [7:0] got;
    int p0;
    match = (addr[7:1] == DEV) && addr[0];
    p0 = pulse_cnt;
    bus_start();
    write_byte(addr, ack);
    check("rd_addr_ack", ack, !match);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, got);
      check("rd_byte", got, match ? data_in : 8'hFF);
    end
    bus_stop();
    #(2 * q);
    check("rd_busy_after_stop", busy, 1'b0);
    check("rd_sda_released", sda_w, 1'b1);
    check("rd_data_out_kept", data_out, exp_dout);
    check("rd_no_pulse", pulse_cnt - p0, 0);
  endtask

  initial begin
    logic ack, s;
    logic [7:0] got, a;
    int p0;
    #5;
    #100;
    check("rst_sda", sda_w, 1'b1);
    check("rst_data_out", data_out, 8'h00);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    #200;

    q = 2500;
    wb[0] = 8'h23;
    txn_write(8'hA0, 1);
    q = 600;

    data_in = 8'h5A;
    txn_read(8'hA1, 1);

    wb[0] = 8'h77;
    txn_write(8'hA2, 1);

    wb[0] = 8'h11; wb[1] = 8'h22;
    txn_write(8'hA0, 2);
    txn_read(8'hA1, 2);

    // Repeated START abandons a half-received data byte.
    p0 = pulse_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    check("rs_addr_ack", ack, 1'b0);
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b1, s);
    bus_start();
    write_byte(8'hA1, ack);
    check("rs_read_ack", ack, 1'b0);
    read_byte(1'b1, got);
    check("rs_read_byte", got, data_in);
    bus_stop();
    #(2 * q);
    check("rs_data_out", data_out, exp_dout);
    check("rs_no_pulse", pulse_cnt - p0, 0);

    // Reset while the address ACK is being driven.
    p0 = pulse_cnt;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(a_bit(8'hA0, i), s);
    m_oe = 1'b0; #(q); scl_m = 1'b1; #(q);
    check("rst_ack_low", sda_w, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_ack_release", sda_w, 1'b1);
    #99;
    rst_n = 1'b1;
    #(q - 100); scl_m = 1'b0; #(q);
    exp_dout = 8'h00;
    write_byte(8'h23, ack);
    check("post_rst_ignored_ack", ack, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    bus_stop();
    #(2 * q);
    check("post_rst_data_out", data_out, 8'h00);
    check("post_rst_no_pulse", pulse_cnt - p0, 0);
    wb[0] = 8'h3C;
    txn_write(8'hA0, 1);

    for (int it = 0; it < 5; it++) begin
      int kind, n;
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      data_in = 8'($urandom);
      for (int i = 0; i < 4; i++) wb[i] = 8'($urandom);
      a = 8'($urandom);
      if (a[7:1] == DEV) a[1] = ~a[1];
      case (kind)
        0: txn_write({DEV, 1'b0}, n);
        1: txn_write({a[7:1], 1'b0}, n);
        2: txn_read({DEV, 1'b1}, n);
        default: txn_read({a[7:1], 1'b1}, n);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic a_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule

// File: doc/iic_slave.md
IIC_SLAVE -- requirements
Module: iic_slave

Interface
REQ-001 Parameter: DEV_ADDR, default 7'h50, 7-bit device address this responder answers to.
REQ-002 Port: clk  input  1  system clock, 50 MHz; every flop is clocked on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: scl  input  1  I2C clock from the master; asynchronous to clk.
REQ-005 Port: sda  inout  1  I2C data, open-drain: the block drives 1'b0 or high-Z only, never 1'b1.
REQ-006 Port: data_in  input  8  byte returned to the master on reads.
REQ-007 Port: data_out  output  8  last byte written by the master.
REQ-008 Port: wr_valid  output  1  one-clk pulse when data_out is updated.
REQ-009 Port: busy  output  1  high from an addressed START until STOP or abandon.

Function
REQ-010 scl and sda are each passed through a 2-flop synchronizer, then a third flop for edge detection; all protocol decisions use the synchronized values.
REQ-011 START: synchronized sda falls while synchronized scl is high; recognized in any state, including mid-byte (repeated START), and enters ADDR with the bit counter cleared.
REQ-012 STOP: synchronized sda rises while synchronized scl is high; recognized in any state; releases sda, clears busy, enters IDLE.
REQ-013 Incoming bits are sampled on the scl rising edge, MSB first; 3-bit bit counter; the byte completes on the 8th rising edge.
REQ-014 sda output changes only on the clk cycle after a detected scl falling edge.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-016 ADDR, on byte complete: if bits[7:1]==DEV_ADDR, go to ADDR_ACK and latch R/W = bit0; else go to IGNORE.
REQ-017 IGNORE: sda released; leaves only on START or STOP.
REQ-018 ADDR_ACK: on the scl falling edge after the 8th bit, drive sda low; hold through the 9th scl high.
REQ-019 ADDR_ACK exit, on the next scl falling edge: if R/W=0, release sda and go to WR_DATA; if R/W=1, load data_in into the shift register, drive its MSB, and go to RD_DATA.
REQ-020 WR_DATA, on byte complete: data_out takes the byte, wr_valid pulses for exactly one clk, and the state goes to WR_ACK (ACK same as REQ-018), then back to WR_DATA.
REQ-021 WR_DATA with multiple bytes: each byte overwrites data_out and pulses wr_valid once.
REQ-022 RD_DATA: shift out the next bit on each scl falling edge; sda released when the bit is 1 and driven low when it is 0.
REQ-023 RD_DATA, after 8 bits: release sda at the 8th falling edge and go to RD_ACK.
REQ-024 RD_ACK: sample the master's sda on the scl rising edge.
REQ-025 RD_ACK, master ACK (0): reload data_in and continue in RD_DATA.
REQ-026 RD_ACK, master NACK (1): stay released and go to IGNORE until STOP or START.
REQ-027 busy is 1 in ADDR_ACK, WR_*, RD_* and 0 otherwise.
REQ-028 A START and STOP condition in the same clk cannot occur, because sda has a single edge; START/STOP detection takes priority over bit sampling in the same cycle.

Reset
REQ-029 While rst_n=0: state=IDLE, sda released (high-Z), data_out=8'h00, wr_valid=0, busy=0, counters and shift register cleared, synchronizers preset to 1.
REQ-030 Reset deasserted mid-transfer: the block remains in IDLE and ignores the bus until the next START.

Verification
REQ-031 Write: bench master at 100 kHz sends START, 8'hA0, 8'h23, STOP -> ACK low on both 9th clocks, data_out=8'h23, exactly one wr_valid pulse, busy low after STOP.
REQ-032 Read: data_in=8'h5A; bench sends START, 8'hA1, NACK after the byte, STOP -> address ACK, sda bits read as 0,1,0,1,1,0,1,0, sda released afterward.
REQ-033 Wrong address: START, 8'hA2, 8'h77, STOP -> sda never driven low, data_out unchanged, wr_valid never pulses.
REQ-034 Burst: START, 8'hA0, 8'h11, 8'h22, STOP, then START, 8'hA1, ACK, NACK -> two wr_valid pulses, final data_out=8'h22, two read bytes both equal to data_in.
REQ-035 Repeated START: START, 8'hA0, 4 bits, START, 8'hA1 -> partial byte discarded, data_out unchanged, read proceeds normally.
REQ-036 rst_n pulsed low during the address ACK -> sda released within the same cycle, and the remainder of the transfer is ignored until the next START.
